xpb_seg_accumulate: RTL and testbench

- Sequential consumer of the 5-bit xpb reduction lookup tables in the modular-square datapath.
- Takes an unreduced value, split as a WIDTH-bit low part plus NSEG 5-bit high segments.
- Walks the high segments one per cycle, drives the segment select and index out to the external xpb table mux, and accumulates the returned WIDTH-bit reduction constants onto the low part.
- Output is a partially reduced sum of ACC_W bits for the next squaring iteration.

---
 rtl/xpb_seg_accumulate.sv | 117 +++++++++++
 tb/tb_xpb_seg_accumulate.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/xpb_seg_accumulate.sv
// Sequential xpb reduction: walks NSEG 5-bit high segments one per cycle, looks each up in the
// external xpb table mux and accumulates the returned constants onto the low part.
module xpb_seg_accumulate #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned NSEG  = 8,
    parameter int unsigned SEG_W = 5,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned ACC_W = 1032
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_low,
    input  logic [NSEG*SEG_W-1:0]   in_high,
    output logic [IDX_W-1:0]        xpb_idx,
    output logic [SEG_W-1:0]        xpb_sel,
    input  logic [WIDTH-1:0]        xpb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum
);

    // Accumulator must hold (NSEG+1)*(2^WIDTH-1) without wrapping.
    if (ACC_W < WIDTH + $clog2(NSEG + 1)) begin : g_bad_acc_w
        $error("xpb_seg_accumulate: ACC_W too narrow for WIDTH/NSEG");
    end
    if (IDX_W != $clog2(NSEG)) begin : g_bad_idx_w
        $error("xpb_seg_accumulate: IDX_W must equal clog2(NSEG)");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

    logic [1:0]              state, state_nxt;
    logic [ACC_W-1:0]        acc, acc_nxt;
    logic [NSEG*SEG_W-1:0]   hi, hi_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic                    out_valid_nxt;
    logic                    in_ready_nxt;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            hi        <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            hi        <= hi_nxt;
            idx       <= idx_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        hi_nxt        = hi;
        idx_nxt       = idx;
        out_valid_nxt = out_valid;
        in_ready_nxt  = in_ready;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    acc_nxt      = ACC_W'(in_low);
                    hi_nxt       = in_high;
                    idx_nxt      = '0;
                    in_ready_nxt = 1'b0;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                acc_nxt = acc + ACC_W'(xpb_data);
                idx_nxt = idx + IDX_W'(1);
                if (idx == LAST_IDX) begin
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                out_valid_nxt = 1'b0;
                in_ready_nxt  = 1'b1;
                state_nxt     = IDLE;
            end
        endcase
    end

    // Table address is combinational so the mux returns the entry in the same cycle.
    always_comb begin
        xpb_idx = '0;
        xpb_sel = '0;
        if (state == RUN) begin
            xpb_idx = idx;
            xpb_sel = hi[int'(idx)*SEG_W +: SEG_W];
        end
    end

    assign out_sum = acc;

endmodule

// File: tb/tb_xpb_seg_accumulate.sv
// Directed bench for xpb_seg_accumulate with table model xpb_data = xpb_sel*(xpb_idx+1).
module tb_xpb_seg_accumulate;

    localparam int unsigned WIDTH = 1024;
    localparam int unsigned NSEG  = 8;
    localparam int unsigned SEG_W = 5;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned ACC_W = 1032;
    localparam int unsigned HW    = NSEG * SEG_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_low;
    logic [HW-1:0]     in_high;
    logic [IDX_W-1:0]  xpb_idx;
    logic [SEG_W-1:0]  xpb_sel;
    logic [WIDTH-1:0]  xpb_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;

    logic              max_mode;
    int                nvec  = 0;
    int                nfail = 0;
    int                cyc   = 0;
    int                acc_times[$];

    xpb_seg_accumulate #(
        .WIDTH(WIDTH), .NSEG(NSEG), .SEG_W(SEG_W), .IDX_W(IDX_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_low(in_low), .in_high(in_high),
        .xpb_idx(xpb_idx), .xpb_sel(xpb_sel), .xpb_data(xpb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (max_mode) xpb_data = '1;
        else          xpb_data = WIDTH'(xpb_sel) * (WIDTH'(xpb_idx) + WIDTH'(1));
    end

    // Log the cycle number of every accepted transaction.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && in_valid && in_ready) acc_times.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed hi=%0h lo=%0h expected hi=%0h lo=%0h", tag,
                   obs[ACC_W-1:WIDTH], obs[63:0], exp[ACC_W-1:WIDTH], exp[63:0]);
        end
    endtask

    // Full transaction with out_ready=1: checks the segment walk, latency and result.
    task automatic txn(input string tag, input logic [WIDTH-1:0] low, input logic [HW-1:0] high,
                       input logic [ACC_W-1:0] exp);
        @(negedge clk);
        chk({tag, " in_ready idle"}, ACC_W'(in_ready), ACC_W'(1));
        in_valid = 1'b1; in_low = low; in_high = high;
        @(negedge clk);
        in_valid = 1'b0; in_low = '0; in_high = '0;
        for (int k = 0; k < int'(NSEG); k++) begin
            chk({tag, " xpb_idx"}, ACC_W'(xpb_idx), ACC_W'(k));
            chk({tag, " xpb_sel"}, ACC_W'(xpb_sel), ACC_W'(high[k*SEG_W +: SEG_W]));
            chk({tag, " out_valid low in run"}, ACC_W'(out_valid), ACC_W'(0));
            @(negedge clk);
        end
        chk({tag, " out_valid"}, ACC_W'(out_valid), ACC_W'(1));
        chk({tag, " out_sum"}, out_sum, exp);
        @(negedge clk);
        chk({tag, " out_valid drop"}, ACC_W'(out_valid), ACC_W'(0));
        chk({tag, " in_ready back"}, ACC_W'(in_ready), ACC_W'(1));
    endtask

    logic [HW-1:0]    ones_seg, twos_seg, ramp_seg, max_seg;
    logic [ACC_W-1:0] big;
    logic [ACC_W-1:0] exp_max;

    initial begin
        for (int k = 0; k < int'(NSEG); k++) begin
            ones_seg[k*SEG_W +: SEG_W] = SEG_W'(1);
            twos_seg[k*SEG_W +: SEG_W] = SEG_W'(2);
            ramp_seg[k*SEG_W +: SEG_W] = SEG_W'(k);
            max_seg[k*SEG_W +: SEG_W]  = SEG_W'(31);
        end
        big     = ACC_W'({WIDTH{1'b1}});
        exp_max = (big << 3) + big;

        reset = 1'b1; in_valid = 1'b0; in_low = '0; in_high = '0;
        out_ready = 1'b1; max_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", ACC_W'(in_ready), ACC_W'(1));
        chk("reset out_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("reset out_sum", out_sum, ACC_W'(0));
        chk("reset xpb_idx", ACC_W'(xpb_idx), ACC_W'(0));
        chk("reset xpb_sel", ACC_W'(xpb_sel), ACC_W'(0));
        reset = 1'b0;

        txn("zero", '0, '0, ACC_W'(0));
        txn("nominal", WIDTH'(5), ones_seg, ACC_W'(41));
        txn("ramp", WIDTH'(100), ramp_seg, ACC_W'(268));

        max_mode = 1'b1;
        txn("max", {WIDTH{1'b1}}, max_seg, exp_max);
        chk("max upper bits", ACC_W'(exp_max[ACC_W-1:WIDTH]), ACC_W'(8));
        max_mode = 1'b0;

        // Backpressure: result held in DONE while new operands are offered.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_low = WIDTH'(5); in_high = ones_seg;
        repeat (9) @(negedge clk);
        in_low = WIDTH'(777); in_high = max_seg;
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid", ACC_W'(out_valid), ACC_W'(1));
            chk("bp out_sum", out_sum, ACC_W'(41));
            chk("bp in_ready", ACC_W'(in_ready), ACC_W'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp handshake out_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("bp handshake in_ready", ACC_W'(in_ready), ACC_W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("bp second out_valid", ACC_W'(out_valid), ACC_W'(1));
        chk("bp second out_sum", out_sum, ACC_W'(1893));
        @(negedge clk);

        // Reset abort during RUN at idx 3.
        in_valid = 1'b1; in_low = WIDTH'(999); in_high = max_seg;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort idx before reset", ACC_W'(xpb_idx), ACC_W'(3));
        reset = 1'b1;
        #1;
        chk("abort out_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("abort in_ready", ACC_W'(in_ready), ACC_W'(1));
        chk("abort xpb_idx", ACC_W'(xpb_idx), ACC_W'(0));
        chk("abort out_sum", out_sum, ACC_W'(0));
        @(negedge clk);
        reset = 1'b0;
        txn("after abort", WIDTH'(5), ones_seg, ACC_W'(41));

        // Back-to-back with in_valid held high.
        @(negedge clk);
        acc_times.delete();
        in_valid = 1'b1; in_low = WIDTH'(5); in_high = ones_seg;
        @(negedge clk);
        in_low = '0; in_high = twos_seg;
        repeat (8) @(negedge clk);
        chk("b2b first out_valid", ACC_W'(out_valid), ACC_W'(1));
        chk("b2b first out_sum", out_sum, ACC_W'(41));
        @(negedge clk);
        chk("b2b in_ready gap", ACC_W'(in_ready), ACC_W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b second running", ACC_W'(in_ready), ACC_W'(0));
        chk("b2b second sel", ACC_W'(xpb_sel), ACC_W'(2));
        repeat (8) @(negedge clk);
        chk("b2b second out_valid", ACC_W'(out_valid), ACC_W'(1));
        chk("b2b second out_sum", out_sum, ACC_W'(72));
        chk("b2b accept count", ACC_W'(acc_times.size()), ACC_W'(2));
        if (acc_times.size() == 2)
            chk("b2b accept spacing", ACC_W'(acc_times[1] - acc_times[0]), ACC_W'(10));
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
